// File: rtl/fetch_stage.sv
// fetch_stage: WISC-F18 instruction fetch -- owns the PC, drives the imem handshake, loads IF/ID.
// Define FETCH_PERF_EN to add saturating fetch/wait performance counters.
//
// state  | meaning
// RUN    | request to imem at pc (suppressed for one cycle after reset)
// HELD   | word captured in skid buffer while stalled; no request
// DRAIN  | redirected with a request in flight; wait it out, target in pending_pc
// HALTED | HLT fetched; idle until a redirect or reset
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc,
  output logic        hlt,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HELD   = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pending_pc, pending_nxt;
  logic [15:0] skid_instr, skid_nxt;
  logic [15:0] pc_nxt;
  logic [15:0] pc_plus2;
  logic [15:0] load_word;
  logic        ifid_load;
  logic        ifid_kill;
  logic        started;

  assign pc_plus2 = pc + 16'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_RUN;
      pc            <= RESET_PC;
      pending_pc    <= 16'h0000;
      skid_instr    <= 16'h0000;
      started       <= 1'b0;
      ifid_valid    <= 1'b0;
      ifid_instr    <= 16'h0000;
      ifid_pc_plus2 <= 16'h0000;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pending_pc <= pending_nxt;
      skid_instr <= skid_nxt;
      started    <= 1'b1;
      if (ifid_kill) begin
        ifid_valid <= 1'b0;
      end else if (ifid_load) begin
        ifid_valid    <= 1'b1;
        ifid_instr    <= load_word;
        ifid_pc_plus2 <= pc_plus2;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pending_nxt = pending_pc;
    skid_nxt    = skid_instr;
    load_word   = imem_rdata;
    ifid_load   = 1'b0;
    ifid_kill   = 1'b0;
    case (state)
      S_RUN: begin
        if (redirect) begin
          ifid_kill = 1'b1;
          if (imem_req && !imem_ready) begin
            state_nxt   = S_DRAIN;
            pending_nxt = redirect_pc;
          end else begin
            pc_nxt = redirect_pc;
          end
        end else if (imem_req && imem_ready) begin
          if (stall_in) begin
            skid_nxt  = imem_rdata;
            state_nxt = S_HELD;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!stall_in) begin
          ifid_kill = 1'b1;
        end
      end
      S_HELD: begin
        if (redirect) begin
          ifid_kill = 1'b1;
          skid_nxt  = 16'h0000;
          pc_nxt    = redirect_pc;
          state_nxt = S_RUN;
        end else if (!stall_in) begin
          load_word = skid_instr;
          ifid_load = 1'b1;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          ifid_kill = 1'b1;
          if (imem_ready) begin
            pc_nxt    = redirect_pc;
            state_nxt = S_RUN;
          end else begin
            pending_nxt = redirect_pc;
          end
        end else begin
          ifid_kill = !stall_in;
          if (imem_ready) begin
            pc_nxt    = pending_pc;
            state_nxt = S_RUN;
          end
        end
      end
      S_HALTED: begin
        if (redirect) begin
          ifid_kill = 1'b1;
          pc_nxt    = redirect_pc;
          state_nxt = S_RUN;
        end else if (!stall_in) begin
          ifid_kill = 1'b1;
        end
      end
      default: state_nxt = S_RUN;
    endcase

    // A delivered HLT freezes pc on its own address; anything else advances.
    if (ifid_load) begin
      if (load_word[15:12] == HALT_OP) begin
        state_nxt = S_HALTED;
      end else begin
        pc_nxt    = pc_plus2;
        state_nxt = S_RUN;
      end
    end
  end

  always_comb begin
    imem_req  = started && ((state == S_RUN) || (state == S_DRAIN));
    imem_addr = pc;
    hlt       = (state == S_HALTED);
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 16'h0000;
      perf_wait_cnt  <= 16'h0000;
    end else begin
      if (ifid_load && !ifid_kill && (perf_fetch_cnt != 16'hFFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (imem_req && !imem_ready && (perf_wait_cnt != 16'hFFFF))
        perf_wait_cnt <= perf_wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipelined instruction-fetch stage for the WISC-F18 core.
- Owns the PC, issues requests to a variable-latency instruction memory (ready handshake), and applies halt and branch redirects from ID.
- Feeds the IF/ID pipeline register that the decode/register-file stage consumes.
- Honours stall and flush from the hazard logic; the ID stage sits directly downstream.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OP, 4'hF, opcode (instr[15:12]) treated as HLT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; imem_addr must stay stable while high until imem_ready.
- imem_addr  out  16  byte address of the requested instruction.
- imem_rdata  in  16  instruction word; valid only when imem_ready=1.
- imem_ready  in  1  one-cycle response strobe for the outstanding request.
- stall_in  in  1  hazard unit: hold the IF/ID contents.
- redirect  in  1  taken branch/jump resolved in ID: flush and refetch.
- redirect_pc  in  16  target address; sampled when redirect=1.
- pc  out  16  current fetch PC (imem_addr in RUN).
- hlt  out  1  high while in HALTED.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_instr  out  16  fetched instruction.
- ifid_pc_plus2  out  16  fetch address + 2 (link value and branch base).

Behaviour:
- Reset (async): pc=RESET_PC, state=RUN, ifid_valid=0, ifid_instr=16'h0000, ifid_pc_plus2=16'h0000, hlt=0, skid buffer empty, imem_req=0 for the first cycle after rst deasserts, then 1.
- Arithmetic: pc+2 is 16-bit modulo. 16'hFFFE wraps to 16'h0000; no error.
- State RUN:
  - imem_req=1, imem_addr=pc.
  - imem_ready & !stall_in & !redirect: IF/ID <= {1, rdata, pc+2}.
  - In the same case: if rdata[15:12]==HALT_OP, pc holds and state goes to HALTED; otherwise pc<=pc+2.
  - imem_ready & stall_in & !redirect: rdata goes into the skid buffer and state goes to HELD; IF/ID holds.
  - !imem_ready & stall_in: IF/ID holds; the request stays outstanding.
- State HELD:
  - imem_req=0.
  - When !stall_in: IF/ID <= the skid entry; pc advances (or halts) by the same rule as RUN; state goes to RUN.
- State DRAIN:
  - Entered on redirect while a request is outstanding and ready has not yet arrived.
  - imem_req stays 1 with the old address; the target is held in pending_pc.
  - On imem_ready: data is discarded, pc<=pending_pc, state goes to RUN.
  - A further redirect in DRAIN overwrites pending_pc.
- State HALTED:
  - imem_req=0, hlt=1. IF/ID obeys stall/flush normally.
  - redirect: the halt was wrong-path, so pc<=redirect_pc, hlt=0, state goes to RUN.
  - Otherwise HALTED persists until rst.
- Redirect priority: redirect beats stall_in and beats imem_ready data in every state.
  - Effect: ifid_valid<=0, skid buffer emptied.
  - If RUN with imem_ready=1 in the same cycle (or in HELD/HALTED): pc<=redirect_pc, state goes to RUN.
  - If RUN with imem_ready=0: state goes to DRAIN.
- Latency: the minimum is one instruction per cycle when imem_ready is high in the request cycle. An instruction appears in IF/ID the cycle after its imem_ready.
- Reset mid-request: the outstanding request is abandoned. The memory must tolerate imem_req dropping.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds two outputs:
  - perf_fetch_cnt [15:0]: increments on each IF/ID load with valid=1.
  - perf_wait_cnt [15:0]: increments each cycle imem_req=1 & !imem_ready.
  - Both saturate at 16'hFFFF and clear on rst.
- When undefined, neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- Zero-wait memory, ready tied high, program ADD,SUB,ADD at 0x0000: ifid_instr takes the three words on consecutive cycles, ifid_pc_plus2 = 0x0002, 0x0004, 0x0006, and pc=0x0006 after the third load.
- 3-cycle latency memory: imem_addr is held at 0x0004 for 3 cycles, ifid_valid is low in between, and a single load occurs with pc_plus2=0x0006.
- stall_in=1 for 2 cycles coincident with ready at pc=0x0010: state goes to HELD with imem_req=0 and IF/ID holds. When the stall drops, IF/ID gets the 0x0010 word, pc_plus2=0x0012, and pc=0x0012.
- redirect=1, redirect_pc=0x0040 while a 3-cycle request to 0x0008 is outstanding: the state enters DRAIN, ifid_valid goes low, and the 0x0008 data is dropped. The next request is to 0x0040.
- Fetch 16'hF000 at 0x0020: hlt=1, pc stays 0x0020, imem_req=0 thereafter. A later redirect to 0x0030 clears hlt and fetches 0x0030.
- Start at pc=0xFFFE: the next fetch address is 0x0000. Asserting rst mid-request immediately gives pc=RESET_PC, ifid_valid=0, hlt=0.
